prach_readout_scheduler: RTL and testbench

//  Round-robin scheduler granting the shared PRACH buffer readout/FFT datapath to one of
//  NUM_REQ antenna-carrier buffers at a time. Sits between per-buffer req/hdr/ack handshakes
//  and the readout sequencer: issues start, holds grant until done, enforces inter-job gap and

---
 rtl/prach_pkg.sv | 18 +
 rtl/prach_rr_pick.sv | 36 +++
 rtl/prach_readout_scheduler.sv | 148 ++++++++++++++
 tb/tb_prach_readout_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH readout scheduler.
// Requester index is cc*NUM_ANT + ant.
package prach_pkg;

    localparam int NUM_CC      = 3;
    localparam int NUM_ANT     = 8;
    localparam int NUM_REQ     = NUM_CC * NUM_ANT;
    localparam int HDR_W       = 120;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/prach_rr_pick.sv
// Circular priority picker: finds the first set request at or after ptr+1,
// wrapping modulo NUM_REQ. The request vector is doubled so the wrap becomes
// a plain lowest-set-bit search above a start mask.
module prach_rr_pick #(
    parameter int NUM_REQ = 24,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0]          start_pos;
    logic [2*NUM_REQ-1:0]   dbl;
    logic [2*NUM_REQ-1:0]   mask;

    // Mask off positions below ptr+1 in the doubled vector, then take the lowest hit.
    always_comb begin
        start_pos = (32'(ptr) >= NUM_REQ - 1) ? '0 : ptr + IW'(1);
        dbl       = {req, req};
        mask      = '0;
        valid     = 1'b0;
        idx       = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            mask[i] = (i >= int'(start_pos));
        end
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (dbl[i] && mask[i]) begin
                valid = 1'b1;
                idx   = (i >= NUM_REQ) ? IW'(i - NUM_REQ) : IW'(i);
            end
        end
    end

endmodule

// File: rtl/prach_readout_scheduler.sv
// Round-robin owner of the shared PRACH readout/FFT datapath.
// Handshake: a buffer raises req (level) with hdr valid and holds both until
// it sees its ack bit; ack stays high for the whole job. start pulses once
// when the grant is issued; done pulses once from the sequencer to end the
// job. After ack falls the buffer must drop req within GAP_CYC cycles or it
// is queued again behind every other pending buffer.
module prach_readout_scheduler #(
    parameter int NUM_REQ     = prach_pkg::NUM_REQ,
    parameter int HDR_W       = prach_pkg::HDR_W,
    parameter int GAP_CYC     = prach_pkg::GAP_CYC,
    parameter int TIMEOUT_CYC = prach_pkg::TIMEOUT_CYC,
    parameter int IW          = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][HDR_W-1:0]   hdr,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            start,
    input  logic                            done,
    output logic [IW-1:0]                   grant_idx,
    output logic [HDR_W-1:0]                grant_hdr,
    output logic                            busy,
    output logic                            timeout_err
);

    import prach_pkg::*;

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    sched_state_e        state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       grant_idx_q, grant_idx_d;
    logic [HDR_W-1:0]    grant_hdr_q, grant_hdr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;

    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic                timeout_hit;
    logic                gap_last;

    prach_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state logic: grant from IDLE, end job on done or watchdog, hold off in GAP.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_hdr_d   = grant_hdr_q;
        ack_d         = ack_q;
        start_d       = 1'b0;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        // A disabled watchdog never fires; done in the same cycle takes priority below.
        timeout_hit   = (TIMEOUT_CYC != 0) && (32'(tmo_cnt_q) == TIMEOUT_CYC - 1);
        gap_last      = (32'(gap_cnt_q) == GAP_CYC - 1);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = ACTIVE;
                    ack_d             = '0;
                    ack_d[pick_idx]   = 1'b1;
                    start_d           = 1'b1;
                    busy_d            = 1'b1;
                    grant_idx_d       = pick_idx;
                    grant_hdr_d       = hdr[pick_idx];
                    tmo_cnt_d         = '0;
                end
            end
            ACTIVE: begin
                if (done || timeout_hit) begin
                    state_d       = (GAP_CYC == 0) ? IDLE : GAP;
                    ack_d         = '0;
                    busy_d        = 1'b0;
                    ptr_d         = grant_idx_q;
                    timeout_err_d = !done;
                    gap_cnt_d     = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; pointer resets to the last index so index 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= IW'(NUM_REQ - 1);
            grant_idx_q   <= '0;
            grant_hdr_q   <= '0;
            ack_q         <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_hdr_q   <= grant_hdr_d;
            ack_q         <= ack_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign ack         = ack_q;
    assign start       = start_q;
    assign grant_idx   = grant_idx_q;
    assign grant_hdr   = grant_hdr_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_prach_readout_scheduler.sv
// Bench for prach_readout_scheduler: directed scenarios plus a randomized
// job stream checked against a round-robin job-level model.
module tb_prach_readout_scheduler;

    localparam int N  = 24;
    localparam int HW = 120;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance: GAP_CYC=2, TIMEOUT_CYC=16
    logic [N-1:0]         req;
    logic [N-1:0][HW-1:0] hdr;
    logic [N-1:0]         ack;
    logic                 start, done, busy, timeout_err;
    logic [4:0]           grant_idx;
    logic [HW-1:0]        grant_hdr;

    // second instance: GAP_CYC=0, watchdog disabled
    logic [N-1:0]         req_b;
    logic [N-1:0][HW-1:0] hdr_b;
    logic [N-1:0]         ack_b;
    logic                 start_b, done_b, busy_b, timeout_err_b;
    logic [4:0]           grant_idx_b;
    logic [HW-1:0]        grant_hdr_b;

    prach_readout_scheduler #(
        .NUM_REQ(N), .HDR_W(HW), .GAP_CYC(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .hdr(hdr), .ack(ack), .start(start),
        .done(done), .grant_idx(grant_idx), .grant_hdr(grant_hdr), .busy(busy),
        .timeout_err(timeout_err)
    );

    prach_readout_scheduler #(
        .NUM_REQ(N), .HDR_W(HW), .GAP_CYC(0), .TIMEOUT_CYC(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .hdr(hdr_b), .ack(ack_b), .start(start_b),
        .done(done_b), .grant_idx(grant_idx_b), .grant_hdr(grant_hdr_b), .busy(busy_b),
        .timeout_err(timeout_err_b)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard queues for the randomized stream
    logic [4:0]    exp_q[$];
    logic [HW-1:0] hdr_q[$];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [HW-1:0] rand_hdr();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[HW-1:0];
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        req_b  = '0;
        done_b = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i);
        hdr[i] = rand_hdr();
        req[i] = 1'b1;
    endtask

    // waits for a start pulse; returns steps taken, or -1 if none within limit
    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (start !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (start !== 1'b1) n = -1;
    endtask

    // reference: first pending index after 'last', wrapping modulo N
    function automatic int rr_next(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", ack); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%0b exp=0", start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got=%0b exp=0", timeout_err); end
        checks++; if (grant_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
        checks++; if (grant_hdr !== '0) begin errors++; $display("FAIL reset_hdr got=%0h exp=0", grant_hdr); end
        checks++; if (ack_b !== '0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b got ack=%0h busy=%0b exp 0/0", ack_b, busy_b); end
        repeat (3) step();
        checks++; if (busy !== 1'b0 || ack !== '0) begin errors++; $display("FAIL idle_no_req got busy=%0b ack=%0h exp 0/0", busy, ack); end
    endtask

    task automatic test_first_grant();
        logic [HW-1:0] h0;
        do_reset();
        set_req(0);
        h0 = hdr[0];
        step();
        checks++; if (ack !== 24'h1) begin errors++; $display("FAIL first_ack got=%0h exp=1", ack); end
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL first_start got=%0b exp=1", start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%0b exp=1", busy); end
        checks++; if (grant_idx !== 5'd0) begin errors++; $display("FAIL first_idx got=%0d exp=0", grant_idx); end
        checks++; if (grant_hdr !== h0) begin errors++; $display("FAIL first_hdr got=%0h exp=%0h", grant_hdr, h0); end
        hdr[0] = rand_hdr();
        step();
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL first_start_pulse got=%0b exp=0", start); end
        checks++; if (grant_hdr !== h0 || ack !== 24'h1) begin errors++; $display("FAIL first_hold got hdr=%0h ack=%0h exp hdr=%0h ack=1", grant_hdr, ack, h0); end
        done   = 1'b1;
        req[0] = 1'b0;
        step();
        done = 1'b0;
        checks++; if (ack !== '0 || busy !== 1'b0) begin errors++; $display("FAIL first_release got ack=%0h busy=%0b exp 0/0", ack, busy); end
        checks++; if (grant_idx !== 5'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL first_after got idx=%0d terr=%0b exp 0/0", grant_idx, timeout_err); end
        repeat (4) step();
    endtask

    task automatic test_rr_order();
        int exp_idx[4];
        int n, bad;
        exp_idx = '{3, 7, 20, 3};
        do_reset();
        set_req(3);
        set_req(7);
        set_req(20);
        for (int j = 0; j < 4; j++) begin
            wait_start(40, n);
            checks++; if (n < 0) begin errors++; $display("FAIL rr_no_start job=%0d got none exp start", j); end
            checks++; if (grant_idx !== 5'(exp_idx[j])) begin errors++; $display("FAIL rr_idx job=%0d got=%0d exp=%0d", j, grant_idx, exp_idx[j]); end
            checks++; if (grant_hdr !== hdr[exp_idx[j]]) begin errors++; $display("FAIL rr_hdr job=%0d got=%0h exp=%0h", j, grant_hdr, hdr[exp_idx[j]]); end
            bad = 0;
            for (int c = 0; c < 9; c++) begin
                if (ack !== (24'(1) << exp_idx[j])) bad++;
                step();
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rr_onehot job=%0d got bad=%0d exp=0", j, bad); end
            done = 1'b1;
            step();
            done = 1'b0;
        end
        req = '0;
        repeat (4) step();
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        set_req(23);
        wait_start(10, n);
        checks++; if (grant_idx !== 5'd23) begin errors++; $display("FAIL wrap_first got=%0d exp=23", grant_idx); end
        done = 1'b1;
        step();
        done = 1'b0;
        set_req(0);
        wait_start(10, n);
        checks++; if (grant_idx !== 5'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", grant_idx); end
        done   = 1'b1;
        req[0] = 1'b0;
        step();
        done = 1'b0;
        wait_start(10, n);
        checks++; if (grant_idx !== 5'd23) begin errors++; $display("FAIL wrap_back got=%0d exp=23", grant_idx); end
        done = 1'b1;
        req  = '0;
        step();
        done = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        set_req(5);
        set_req(9);
        wait_start(10, n);
        checks++; if (grant_idx !== 5'd5) begin errors++; $display("FAIL tmo_idx got=%0d exp=5", grant_idx); end
        n = 0;
        while (ack[5] === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL tmo_len got=%0d exp=16", n); end
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_err got terr=%0b busy=%0b exp 1/0", timeout_err, busy); end
        req[5] = 1'b0;
        step();
        checks++; if (timeout_err !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL tmo_pulse got terr=%0b start=%0b exp 0/0", timeout_err, start); end
        step();
        checks++; if (start !== 1'b0 || ack !== '0) begin errors++; $display("FAIL tmo_gap got start=%0b ack=%0h exp 0/0", start, ack); end
        step();
        checks++; if (start !== 1'b1 || grant_idx !== 5'd9) begin errors++; $display("FAIL tmo_next got start=%0b idx=%0d exp 1/9", start, grant_idx); end
        repeat (15) step();
        checks++; if (ack !== (24'(1) << 9)) begin errors++; $display("FAIL tmo_edge_hold got=%0h exp=%0h", ack, 24'(1) << 9); end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (ack !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_done_wins got ack=%0h terr=%0b exp 0/0", ack, timeout_err); end
        req = '0;
        repeat (4) step();
    endtask

    task automatic test_gap();
        int n, bad;
        do_reset();
        set_req(2);
        wait_start(10, n);
        done = 1'b1;
        step();
        done   = 1'b0;
        req[2] = 1'b0;
        set_req(11);
        step();
        checks++; if (start !== 1'b0 || ack !== '0) begin errors++; $display("FAIL gap1 got start=%0b ack=%0h exp 0/0", start, ack); end
        checks++; if (grant_idx !== 5'd2) begin errors++; $display("FAIL gap_idx_hold got=%0d exp=2", grant_idx); end
        req[11] = 1'b0;
        done    = 1'b1;
        set_req(4);
        step();
        checks++; if (start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gap2 got start=%0b busy=%0b exp 0/0", start, busy); end
        done = 1'b0;
        set_req(11);
        step();
        checks++; if (start !== 1'b1 || grant_idx !== 5'd4) begin errors++; $display("FAIL gap_next got start=%0b idx=%0d exp 1/4", start, grant_idx); end
        done = 1'b1;
        req  = '0;
        step();
        done = 1'b0;
        // zero-gap instance with the watchdog disabled
        hdr_b[6] = rand_hdr();
        req_b[6] = 1'b1;
        step();
        checks++; if (start_b !== 1'b1 || grant_idx_b !== 5'd6 || grant_hdr_b !== hdr_b[6]) begin errors++; $display("FAIL b_grant got start=%0b idx=%0d exp 1/6", start_b, grant_idx_b); end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ack_b !== (24'(1) << 6) || timeout_err_b !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b_no_watchdog got bad=%0d exp=0", bad); end
        done_b   = 1'b1;
        req_b[6] = 1'b0;
        hdr_b[1] = rand_hdr();
        req_b[1] = 1'b1;
        step();
        done_b = 1'b0;
        checks++; if (ack_b !== '0 || start_b !== 1'b0) begin errors++; $display("FAIL b_release got ack=%0h start=%0b exp 0/0", ack_b, start_b); end
        step();
        checks++; if (start_b !== 1'b1 || grant_idx_b !== 5'd1) begin errors++; $display("FAIL b_nogap got start=%0b idx=%0d exp 1/1", start_b, grant_idx_b); end
        done_b = 1'b1;
        req_b  = '0;
        step();
        done_b = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        set_req(0);
        wait_start(10, n);
        done   = 1'b1;
        req[0] = 1'b0;
        step();
        done = 1'b0;
        set_req(10);
        set_req(0);
        wait_start(10, n);
        checks++; if (grant_idx !== 5'd10) begin errors++; $display("FAIL mid_pre got=%0d exp=10", grant_idx); end
        repeat (3) step();
        rst_n = 1'b0;
        step();
        checks++; if (ack !== '0 || busy !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL mid_rst got ack=%0h busy=%0b start=%0b exp 0/0/0", ack, busy, start); end
        checks++; if (timeout_err !== 1'b0 || grant_idx !== 5'd0 || grant_hdr !== '0) begin errors++; $display("FAIL mid_rst_regs got terr=%0b idx=%0d hdr=%0h exp 0/0/0", timeout_err, grant_idx, grant_hdr); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (start !== 1'b1 || grant_idx !== 5'd0) begin errors++; $display("FAIL mid_after got start=%0b idx=%0d exp 1/0", start, grant_idx); end
        done = 1'b1;
        req  = '0;
        step();
        done = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_random();
        logic [N-1:0] pending;
        logic [N-1:0] oh;
        int last, widx, w_done, exp_len, k, n, bad, tbad, a;
        logic [4:0]    e_idx;
        logic [HW-1:0] e_hdr;
        do_reset();
        pending = '0;
        last    = N - 1;
        k       = 0;
        w_done  = -1;
        repeat ($urandom_range(1, 4)) begin
            a = $urandom_range(0, N - 1);
            if (!pending[a]) begin set_req(a); pending[a] = 1'b1; end
        end
        for (int job = 0; job < 40; job++) begin
            widx = rr_next(pending, last);
            exp_q.push_back(5'(widx));
            hdr_q.push_back(hdr[widx]);
            oh   = 24'(1) << widx;
            n    = 0;
            tbad = 0;
            while (start !== 1'b1 && n < 10) begin
                done = (k == w_done);
                step();
                k++;
                n++;
                if (timeout_err !== 1'b0) tbad++;
            end
            done  = 1'b0;
            e_idx = exp_q.pop_front();
            e_hdr = hdr_q.pop_front();
            checks++; if (n != ((job == 0) ? 1 : 3)) begin errors++; $display("FAIL rnd_latency job=%0d got=%0d exp=%0d", job, n, (job == 0) ? 1 : 3); end
            checks++; if (grant_idx !== e_idx) begin errors++; $display("FAIL rnd_idx job=%0d got=%0d exp=%0d", job, grant_idx, e_idx); end
            checks++; if (grant_hdr !== e_hdr) begin errors++; $display("FAIL rnd_hdr job=%0d got=%0h exp=%0h", job, grant_hdr, e_hdr); end
            checks++; if (ack !== oh || busy !== 1'b1) begin errors++; $display("FAIL rnd_ack job=%0d got=%0h exp=%0h", job, ack, oh); end
            checks++; if (tbad != 0) begin errors++; $display("FAIL rnd_stray_terr job=%0d got=%0d exp=0", job, tbad); end
            repeat ($urandom_range(0, 2)) begin
                a = $urandom_range(0, N - 1);
                if (!pending[a]) begin set_req(a); pending[a] = 1'b1; end
            end
            w_done  = $urandom_range(0, 17);
            exp_len = (w_done <= 15) ? w_done + 1 : 16;
            k       = 0;
            bad     = 0;
            while (k < exp_len) begin
                done = (k == w_done);
                step();
                k++;
                if (k < exp_len && ack !== oh) bad++;
            end
            done = 1'b0;
            checks++; if (bad != 0) begin errors++; $display("FAIL rnd_hold job=%0d got bad=%0d exp=0", job, bad); end
            checks++; if (ack !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_end job=%0d got ack=%0h busy=%0b exp 0/0", job, ack, busy); end
            checks++; if (timeout_err !== (w_done > 15)) begin errors++; $display("FAIL rnd_terr job=%0d got=%0b exp=%0b", job, timeout_err, w_done > 15); end
            last = widx;
            if ($urandom_range(0, 3) != 0) begin
                req[widx]     = 1'b0;
                pending[widx] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin
                a = $urandom_range(0, N - 1);
                if (!pending[a]) begin set_req(a); pending[a] = 1'b1; end
            end
            if (pending == '0) begin
                a = $urandom_range(0, N - 1);
                set_req(a);
                pending[a] = 1'b1;
            end
        end
        req  = '0;
        done = 1'b0;
        repeat (25) step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n  = 1'b0;
        req    = '0;
        hdr    = '0;
        done   = 1'b0;
        req_b  = '0;
        hdr_b  = '0;
        done_b = 1'b0;
        test_reset();
        test_first_grant();
        test_rr_order();
        test_wrap();
        test_timeout();
        test_gap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
